// File: rtl/sdf_stage_ctrl_if.sv
// rtl/sdf_stage_ctrl_if.sv - sample handshake and stage-control bundle for sdf_stage_ctrl
// Purpose: groups the upstream sample handshake and the control outputs that
// drive one radix-2 SDF stage's shift register and butterfly.
// Signals:
//   valid_i, ready_o        sample handshake, accept = valid_i && ready_o
//   data_in_r, data_in_i    signed input sample (W bits per component)
//   data_out_r, data_out_i  registered accepted sample, aligned with mode_o
//   mode_o                  00 IDLE, 01 FILL, 10 BFLY, 11 DRAIN
//   sr_en_o                 feedback shift-register advance enable
//   tw_idx_o                twiddle index
//   valid_o                 butterfly output is a real result
//   sop_o, eop_o            first / last output of a stage frame
// Modports: master = upstream/consumer side, slave = controller side.
interface sdf_stage_ctrl_if #(
   parameter int W = 16
);
   logic                valid_i;
   logic                ready_o;
   logic signed [W-1:0] data_in_r;
   logic signed [W-1:0] data_in_i;
   logic signed [W-1:0] data_out_r;
   logic signed [W-1:0] data_out_i;
   logic [1:0]          mode_o;
   logic                sr_en_o;
   logic [3:0]          tw_idx_o;
   logic                valid_o;
   logic                sop_o;
   logic                eop_o;

   modport master (
      output valid_i, data_in_r, data_in_i,
      input  ready_o, data_out_r, data_out_i, mode_o, sr_en_o, tw_idx_o,
             valid_o, sop_o, eop_o
   );

   modport slave (
      input  valid_i, data_in_r, data_in_i,
      output ready_o, data_out_r, data_out_i, mode_o, sr_en_o, tw_idx_o,
             valid_o, sop_o, eop_o
   );
endinterface

// File: rtl/sdf_stage_ctrl.sv
// rtl/sdf_stage_ctrl.sv - sequencer for one radix-2 single-delay-feedback FFT stage
// Purpose: accepts the stage input stream and generates butterfly mode,
// shift-register enable, twiddle index and frame markers for a stage with
// delay D = 2**LOG_D (frame length 2D). Stalls the feedback register across
// input gaps and drains the stored half-frame when the stream stops.
// Parameters: LOG_D (0..4) feedback delay exponent, W sample component width.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  sdf_stage_ctrl_if.slave: valid_i/ready_o handshake, data_in_*,
//        data_out_*, mode_o, sr_en_o, tw_idx_o, valid_o, sop_o, eop_o
module sdf_stage_ctrl #(
   parameter int LOG_D = 0,
   parameter int W     = 16
) (
   input  logic            clk,
   input  logic            rst,
   sdf_stage_ctrl_if.slave bus
);
   localparam int CW = LOG_D + 1;
   localparam int D  = 1 << LOG_D;

   localparam logic [CW-1:0] CNT_D    = CW'(D);
   localparam logic [CW-1:0] CNT_D_M1 = CW'(D - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(2 * D - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] MODE_IDLE  = 2'b00;
   localparam logic [1:0] MODE_FILL  = 2'b01;
   localparam logic [1:0] MODE_BFLY  = 2'b10;
   localparam logic [1:0] MODE_DRAIN = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [CW-1:0]       dcnt_q, dcnt_d;
   logic                pend_q, pend_d;
   logic                ready_q, ready_d;
   logic [1:0]          mode_q, mode_d;
   logic                sr_en_q, sr_en_d;
   logic                valid_q, valid_d;
   logic                sop_q, sop_d;
   logic                eop_q, eop_d;
   logic [3:0]          tw_q, tw_d;
   logic signed [W-1:0] dr_q, dr_d;
   logic signed [W-1:0] di_q, di_d;
   logic                accept;
   logic                phase;

   assign accept = bus.valid_i && ready_q;
   assign phase  = cnt_q[LOG_D];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dcnt_q  <= '0;
         pend_q  <= 1'b0;
         ready_q <= 1'b1;
         mode_q  <= MODE_IDLE;
         sr_en_q <= 1'b0;
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         tw_q    <= '0;
         dr_q    <= '0;
         di_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dcnt_q  <= dcnt_d;
         pend_q  <= pend_d;
         ready_q <= ready_d;
         mode_q  <= mode_d;
         sr_en_q <= sr_en_d;
         valid_q <= valid_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         tw_q    <= tw_d;
         dr_q    <= dr_d;
         di_q    <= di_d;
      end
   end

   // Defaults describe a stalled cycle: everything held, nothing advances.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dcnt_d  = dcnt_q;
      pend_d  = pend_q;
      ready_d = 1'b1;
      mode_d  = mode_q;
      sr_en_d = 1'b0;
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      tw_d    = tw_q;
      dr_d    = dr_q;
      di_d    = di_q;

      // The first DRAIN-state cycle still shows the registered ready_o = 1,
      // so a sample arriving there is honoured and cancels the drain, exactly
      // as if it had been present on the edge that decided to drain.
      if (accept) begin
         state_d = ST_RUN;
         cnt_d   = cnt_q + CNT_ONE;
         sr_en_d = 1'b1;
         mode_d  = phase ? MODE_BFLY : MODE_FILL;
         tw_d    = 4'(cnt_q & CNT_D_M1);
         dr_d    = bus.data_in_r;
         di_d    = bus.data_in_i;
         // FILL pushes out the previous frame's differences, if any exist.
         valid_d = phase | pend_q;
         sop_d   = (cnt_q == CNT_D);
         eop_d   = (cnt_q == CNT_D_M1) && pend_q;
         if (cnt_q == CNT_LAST) begin
            pend_d = 1'b1;
         end else if (cnt_q == CNT_D_M1) begin
            pend_d = 1'b0;
         end
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               mode_d = MODE_IDLE;
               tw_d   = '0;
               dr_d   = '0;
               di_d   = '0;
            end
            ST_RUN: begin
               // Frame boundary with nothing arriving: flush stored differences.
               if (cnt_q == '0) begin
                  if (pend_q) begin
                     state_d = ST_DRAIN;
                     dcnt_d  = CNT_D;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_DRAIN: begin
               ready_d = 1'b0;
               mode_d  = MODE_DRAIN;
               sr_en_d = 1'b1;
               valid_d = 1'b1;
               tw_d    = '0;
               dr_d    = '0;
               di_d    = '0;
               dcnt_d  = dcnt_q - CNT_ONE;
               if (dcnt_q == CNT_ONE) begin
                  eop_d   = 1'b1;
                  pend_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ready_o    = ready_q;
   assign bus.mode_o     = mode_q;
   assign bus.sr_en_o    = sr_en_q;
   assign bus.valid_o    = valid_q;
   assign bus.sop_o      = sop_q;
   assign bus.eop_o      = eop_q;
   assign bus.tw_idx_o   = tw_q;
   assign bus.data_out_r = dr_q;
   assign bus.data_out_i = di_q;
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb/tb_sdf_stage_ctrl.sv - self-checking bench for sdf_stage_ctrl
module tb_sdf_stage_ctrl;
   localparam logic [1:0] M_IDLE  = 2'b00;
   localparam logic [1:0] M_FILL  = 2'b01;
   localparam logic [1:0] M_BFLY  = 2'b10;
   localparam logic [1:0] M_DRAIN = 2'b11;

   typedef struct packed {
      logic        vin;
      logic [15:0] din;
      logic [1:0]  mode;
      logic        sr;
      logic        vo;
      logic        sop;
      logic        eop;
      logic        rdy;
      logic [3:0]  tw;
      logic        chk_tw;
      logic [15:0] dr;
      logic [15:0] di;
      logic        chk_dat;
   } vec_t;

   logic clk = 1'b0;
   logic rst0, rst1, rst2, rst4;
   int   n_run  = 0;
   int   n_fail = 0;
   vec_t sb_q[$];
   vec_t tbl[$];

   sdf_stage_ctrl_if #(.W(16)) b0 ();
   sdf_stage_ctrl_if #(.W(16)) b1 ();
   sdf_stage_ctrl_if #(.W(16)) b2 ();
   sdf_stage_ctrl_if #(.W(16)) b4 ();

   sdf_stage_ctrl #(.LOG_D(0), .W(16)) u0 (.clk(clk), .rst(rst0), .bus(b0));
   sdf_stage_ctrl #(.LOG_D(1), .W(16)) u1 (.clk(clk), .rst(rst1), .bus(b1));
   sdf_stage_ctrl #(.LOG_D(2), .W(16)) u2 (.clk(clk), .rst(rst2), .bus(b2));
   sdf_stage_ctrl #(.LOG_D(4), .W(16)) u4 (.clk(clk), .rst(rst4), .bus(b4));

   always #5 clk = ~clk;

   function automatic vec_t acc(input logic [15:0] d, input logic [1:0] m, input logic vo,
                                input logic sop, input logic eop, input logic [3:0] tw);
      vec_t v;
      v = '0;
      v.vin = 1'b1; v.din = d; v.mode = m; v.sr = 1'b1; v.vo = vo; v.sop = sop;
      v.eop = eop; v.rdy = 1'b1; v.tw = tw; v.chk_tw = 1'b1;
      v.dr = d; v.di = ~d; v.chk_dat = 1'b1;
      return v;
   endfunction

   function automatic vec_t gap(input logic [1:0] m);
      vec_t v;
      v = '0;
      v.din = 16'hdead; v.mode = m; v.rdy = 1'b1;
      return v;
   endfunction

   function automatic vec_t drn(input logic eop, input logic vin, input logic [15:0] d);
      vec_t v;
      v = '0;
      v.vin = vin; v.din = d; v.mode = M_DRAIN; v.sr = 1'b1; v.vo = 1'b1;
      v.eop = eop; v.rdy = 1'b0; v.chk_dat = 1'b1;
      return v;
   endfunction

   function automatic vec_t idl(input logic vin, input logic [15:0] d);
      vec_t v;
      v = '0;
      v.vin = vin; v.din = d; v.mode = M_IDLE; v.rdy = 1'b1;
      return v;
   endfunction

   function automatic vec_t rst_exp();
      vec_t v;
      v = '0;
      v.rdy = 1'b1; v.chk_tw = 1'b1; v.chk_dat = 1'b1;
      return v;
   endfunction

   task automatic drive(input int sel, input logic v, input logic [15:0] d);
      case (sel)
         0: begin b0.valid_i = v; b0.data_in_r = d; b0.data_in_i = ~d; end
         1: begin b1.valid_i = v; b1.data_in_r = d; b1.data_in_i = ~d; end
         2: begin b2.valid_i = v; b2.data_in_r = d; b2.data_in_i = ~d; end
         default: begin b4.valid_i = v; b4.data_in_r = d; b4.data_in_i = ~d; end
      endcase
   endtask

   function automatic vec_t observe(input int sel);
      vec_t o;
      o = '0;
      case (sel)
         0: begin
            o.mode = b0.mode_o; o.sr = b0.sr_en_o; o.vo = b0.valid_o; o.sop = b0.sop_o;
            o.eop = b0.eop_o; o.rdy = b0.ready_o; o.tw = b0.tw_idx_o;
            o.dr = b0.data_out_r; o.di = b0.data_out_i;
         end
         1: begin
            o.mode = b1.mode_o; o.sr = b1.sr_en_o; o.vo = b1.valid_o; o.sop = b1.sop_o;
            o.eop = b1.eop_o; o.rdy = b1.ready_o; o.tw = b1.tw_idx_o;
            o.dr = b1.data_out_r; o.di = b1.data_out_i;
         end
         2: begin
            o.mode = b2.mode_o; o.sr = b2.sr_en_o; o.vo = b2.valid_o; o.sop = b2.sop_o;
            o.eop = b2.eop_o; o.rdy = b2.ready_o; o.tw = b2.tw_idx_o;
            o.dr = b2.data_out_r; o.di = b2.data_out_i;
         end
         default: begin
            o.mode = b4.mode_o; o.sr = b4.sr_en_o; o.vo = b4.valid_o; o.sop = b4.sop_o;
            o.eop = b4.eop_o; o.rdy = b4.ready_o; o.tw = b4.tw_idx_o;
            o.dr = b4.data_out_r; o.di = b4.data_out_i;
         end
      endcase
      return o;
   endfunction

   task automatic cmp(input int sel, input vec_t e, input string name, input int idx);
      vec_t o;
      logic bad;
      o = observe(sel);
      bad = (o.mode !== e.mode) || (o.sr !== e.sr) || (o.vo !== e.vo) ||
            (o.sop !== e.sop) || (o.eop !== e.eop) || (o.rdy !== e.rdy) ||
            (e.chk_tw && (o.tw !== e.tw)) ||
            (e.chk_dat && ((o.dr !== e.dr) || (o.di !== e.di)));
      n_run++;
      if (bad) begin
         n_fail++;
         $display("FAIL %s[%0d]: got mode=%b sr=%b vo=%b sop=%b eop=%b rdy=%b tw=%0d dr=%h di=%h; want mode=%b sr=%b vo=%b sop=%b eop=%b rdy=%b tw=%0d(chk %b) dr=%h di=%h(chk %b)",
                  name, idx, o.mode, o.sr, o.vo, o.sop, o.eop, o.rdy, o.tw, o.dr, o.di,
                  e.mode, e.sr, e.vo, e.sop, e.eop, e.rdy, e.tw, e.chk_tw, e.dr, e.di, e.chk_dat);
      end
   endtask

   // Drive one vector, queue its expectation, and check it once the DUT responds.
   task automatic apply(input int sel, input vec_t v, input string name, input int idx);
      vec_t e;
      drive(sel, v.vin, v.din);
      sb_q.push_back(v);
      @(negedge clk);
      if (sb_q.size() == 0) begin
         n_run++;
         n_fail++;
         $display("FAIL %s[%0d]: scoreboard empty", name, idx);
      end else begin
         e = sb_q.pop_front();
         cmp(sel, e, name, idx);
      end
   endtask

   task automatic run_table(input int sel, input string name);
      for (int k = 0; k < tbl.size(); k++) apply(sel, tbl[k], name, k);
      drive(sel, 1'b0, 16'h0000);
   endtask

   initial begin
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;
      for (int s = 0; s < 4; s++) drive(s, 1'b0, 16'h0000);
      drive(4, 1'b0, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      cmp(0, rst_exp(), "reset_d1", 0);
      cmp(1, rst_exp(), "reset_d2", 0);
      cmp(2, rst_exp(), "reset_d4", 0);
      cmp(4, rst_exp(), "reset_d16", 0);
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst4 = 1'b1;
      @(negedge clk);

      // LOG_D=0: four samples then stream stops; single-cycle drain.
      tbl.delete();
      tbl.push_back(acc(16'h1111, M_FILL, 1'b0, 1'b0, 1'b0, 4'd0));
      tbl.push_back(acc(16'h2222, M_BFLY, 1'b1, 1'b1, 1'b0, 4'd0));
      tbl.push_back(acc(16'h3333, M_FILL, 1'b1, 1'b0, 1'b1, 4'd0));
      tbl.push_back(acc(16'h4444, M_BFLY, 1'b1, 1'b1, 1'b0, 4'd0));
      tbl.push_back(gap(M_BFLY));
      tbl.push_back(drn(1'b1, 1'b0, 16'h0000));
      tbl.push_back(idl(1'b0, 16'h0000));
      tbl.push_back(idl(1'b0, 16'h0000));
      run_table(0, "d1_frame");

      // LOG_D=0: sample at cnt=0 with pending=1 wins over drain entry.
      tbl.delete();
      tbl.push_back(acc(16'h0a01, M_FILL, 1'b0, 1'b0, 1'b0, 4'd0));
      tbl.push_back(acc(16'h0a02, M_BFLY, 1'b1, 1'b1, 1'b0, 4'd0));
      tbl.push_back(acc(16'h0a03, M_FILL, 1'b1, 1'b0, 1'b1, 4'd0));
      tbl.push_back(acc(16'h0a04, M_BFLY, 1'b1, 1'b1, 1'b0, 4'd0));
      tbl.push_back(gap(M_BFLY));
      tbl.push_back(drn(1'b1, 1'b0, 16'h0000));
      tbl.push_back(idl(1'b0, 16'h0000));
      run_table(0, "d1_priority");

      // LOG_D=2: 16 back-to-back samples, then drain of 4.
      tbl.delete();
      for (int i = 0; i < 16; i++)
         tbl.push_back(acc(16'($urandom), ((i % 8) >= 4) ? M_BFLY : M_FILL,
                           ((i % 8) >= 4) || (i >= 8), (i % 8) == 4, i == 11, 4'(i % 4)));
      tbl.push_back(gap(M_BFLY));
      for (int i = 0; i < 4; i++) tbl.push_back(drn(i == 3, 1'b0, 16'h0000));
      tbl.push_back(idl(1'b0, 16'h0000));
      tbl.push_back(idl(1'b0, 16'h0000));
      run_table(2, "d4_stream");

      // LOG_D=2: 3-cycle gap at cnt=5.
      tbl.delete();
      for (int i = 0; i < 5; i++)
         tbl.push_back(acc(16'($urandom), (i >= 4) ? M_BFLY : M_FILL, i >= 4, i == 4, 1'b0, 4'(i % 4)));
      for (int i = 0; i < 3; i++) tbl.push_back(gap(M_BFLY));
      for (int i = 5; i < 8; i++)
         tbl.push_back(acc(16'($urandom), M_BFLY, 1'b1, 1'b0, 1'b0, 4'(i % 4)));
      tbl.push_back(gap(M_BFLY));
      for (int i = 0; i < 4; i++) tbl.push_back(drn(i == 3, 1'b0, 16'h0000));
      tbl.push_back(idl(1'b0, 16'h0000));
      run_table(2, "d4_gap");

      // LOG_D=4: one frame, 16-cycle drain with a sample held during it.
      tbl.delete();
      for (int i = 0; i < 32; i++)
         tbl.push_back(acc(16'($urandom), (i >= 16) ? M_BFLY : M_FILL, i >= 16, i == 16, 1'b0, 4'(i % 16)));
      tbl.push_back(gap(M_BFLY));
      tbl.push_back(drn(1'b0, 1'b0, 16'h0000));
      for (int i = 1; i < 16; i++) tbl.push_back(drn(i == 15, 1'b1, 16'h5a5a));
      tbl.push_back(idl(1'b1, 16'h5a5a));
      tbl.push_back(acc(16'h5a5a, M_FILL, 1'b0, 1'b0, 1'b0, 4'd0));
      tbl.push_back(gap(M_FILL));
      run_table(4, "d16_drain");

      // LOG_D=1: reset asserted while in BFLY, then a fresh frame.
      tbl.delete();
      tbl.push_back(acc(16'h0101, M_FILL, 1'b0, 1'b0, 1'b0, 4'd0));
      tbl.push_back(acc(16'h0202, M_FILL, 1'b0, 1'b0, 1'b0, 4'd1));
      tbl.push_back(acc(16'h0303, M_BFLY, 1'b1, 1'b1, 1'b0, 4'd0));
      run_table(1, "d2_pre_rst");
      rst1 = 1'b0;
      #1;
      cmp(1, rst_exp(), "d2_async_rst", 0);
      @(negedge clk);
      rst1 = 1'b1;
      tbl.delete();
      tbl.push_back(acc(16'h0404, M_FILL, 1'b0, 1'b0, 1'b0, 4'd0));
      tbl.push_back(acc(16'h0505, M_FILL, 1'b0, 1'b0, 1'b0, 4'd1));
      tbl.push_back(acc(16'h0606, M_BFLY, 1'b1, 1'b1, 1'b0, 4'd0));
      tbl.push_back(acc(16'h0707, M_BFLY, 1'b1, 1'b0, 1'b0, 4'd1));
      tbl.push_back(gap(M_BFLY));
      tbl.push_back(drn(1'b0, 1'b0, 16'h0000));
      tbl.push_back(drn(1'b1, 1'b0, 16'h0000));
      tbl.push_back(idl(1'b0, 16'h0000));
      run_table(1, "d2_post_rst");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/sdf_stage_ctrl.md
# sdf_stage_ctrl

Parameterized sequencer for one radix-2 single-delay-feedback (SDF) FFT stage with delay D = 2^LOG_D. It accepts the stage's input sample stream under a valid/ready handshake and produces the signals the stage needs: butterfly mode, shift-register enable, twiddle index, and frame markers. It also stalls the feedback shift register across input gaps and drains the stored half-frame when the stream stops. It sits between the previous stage's output and the stage's shift register and butterfly; one instance serves each stage of the 32-point pipeline (LOG_D = 4..0).

## Interface
- LOG_D, default 0: log2 of the feedback delay; legal range 0..4. Stage frame length is 2D.
- W, default 16: sample width per real/imag component.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  input sample valid.
- ready_o  out  1  controller can accept a sample; a sample is accepted when valid_i && ready_o.
- data_in_r, data_in_i  in  W each  signed input sample.
- data_out_r, data_out_i  out  W each  registered accepted sample, aligned with mode_o.
- mode_o  out  2  butterfly mode: 00 IDLE, 01 FILL, 10 BFLY, 11 DRAIN.
- sr_en_o  out  1  shift-register advance enable.
- tw_idx_o  out  4  twiddle index = cnt[LOG_D-1:0], zero-extended; always 0 when LOG_D=0.
- valid_o  out  1  the butterfly output is a real result this cycle.
- sop_o, eop_o  out  1 each  first and last output of a stage frame.

## Operation
- **State and counters:**
  - FSM states: IDLE, RUN, DRAIN.
  - Phase counter cnt has LOG_D+1 bits and runs modulo 2D. Phase = cnt[LOG_D]: 0 is FILL, 1 is BFLY.
  - Drain counter dcnt has LOG_D+1 bits.
  - Flag pending means the shift register holds the differences of a completed BFLY half.
- **Accepting a sample (IDLE or RUN):**
  - Next cycle: data_out = sample, sr_en_o = 1, mode_o = FILL or BFLY per the phase, tw_idx_o = low cnt bits.
  - cnt increments after each accepted sample.
- **valid_o:**
  - In BFLY: 1.
  - In FILL: equal to pending, because FILL emits the previous frame's stored differences.
- **Frame markers:**
  - sop_o = 1 with the BFLY output at cnt = D.
  - eop_o = 1 with the last difference output: FILL at cnt = D-1 with pending = 1, or the last DRAIN cycle.
- **pending:**
  - Set when cnt wraps from 2D-1 to 0.
  - Cleared when a FILL half completes without a new BFLY half having started, i.e. once the differences have been emitted. pending is therefore always 1 entering FILL after a completed frame.
- **Gap mid-phase** (valid_i = 0, cnt ≠ 0): registered outputs hold mode_o, with sr_en_o = 0, valid_o = 0, sop_o = eop_o = 0. cnt is unchanged.
- **Entering DRAIN:** when valid_i = 0 with cnt = 0 and pending = 1, go to DRAIN and load dcnt = D.
- **DRAIN:**
  - ready_o = 0, mode_o = DRAIN, sr_en_o = 1, valid_o = 1, data_out = 0.
  - dcnt decrements each cycle; eop_o = 1 when dcnt = 1.
  - Then pending is cleared and the FSM goes to IDLE.
  - valid_i asserted during DRAIN is not accepted; upstream holds the sample.
- **IDLE:** mode_o = IDLE, sr_en_o = 0, valid_o = 0, cnt = 0.
- **Reset mid-operation:** all state and outputs return to reset values immediately. Shift-register contents are don't-care; pending = 0 guarantees they are never marked valid.

## Timing
- **Reset values:** ready_o = 1; all other outputs = 0. FSM = IDLE, cnt = 0, dcnt = 0, pending = 0.
- **Latency:** 1 cycle from the accepting edge to data_out, mode_o, sr_en_o, valid_o, sop_o, eop_o and tw_idx_o.
- **ready_o** is registered: 0 exactly during DRAIN cycles and 1 on the cycle after the last DRAIN cycle.
- **Back-to-back frames:** no bubbles; a new frame's FILL phase outputs the previous frame's differences.
- **Drain length:** exactly D cycles. Total stall seen upstream is D cycles.
- **Simultaneous events:** a valid sample at cnt = 0 with pending = 1 takes priority over drain entry; no DRAIN occurs.

## Test plan
- LOG_D=0, valid_i high for edges 0-3 (samples a, b, c, d), then low:
  - mode_o = FILL, BFLY, FILL, BFLY on cycles 1-4, then DRAIN on cycle 6.
  - valid_o = 0, 1, 1, 1, then 1 at DRAIN.
  - sop_o on cycles 2 and 4; eop_o on cycles 3 and 6.
  - ready_o = 0 only on cycle 6; IDLE on cycle 7.
- LOG_D=2, 16 continuous samples: tw_idx_o cycles 0, 1, 2, 3; sr_en_o is continuously 1; valid_o = 0 on the first 4 outputs and 1 on the remaining 12; no DRAIN occurs.
- LOG_D=2, valid_i dropped for 3 cycles at cnt = 5: outputs hold mode BFLY with sr_en_o = 0 and valid_o = 0 for 3 cycles; the stream resumes with tw_idx_o = 1.
- LOG_D=4, one frame then idle: exactly 16 DRAIN cycles with ready_o = 0 and data_out = 0; eop_o on the 16th; a valid_i held during the drain is accepted on the first cycle after the drain as FILL with valid_o = 0.
- Reset asserted during BFLY at LOG_D=1: all outputs are 0 and ready_o = 1 immediately; the next frame starts with valid_o = 0 in FILL.
- Sample presented at cnt = 0 with pending = 1 on the same edge drain would be decided: the sample is accepted and no DRAIN occurs.
